seq_retire_monitor: RTL and testbench

//  Synthesizable run-control and trace monitor for seq_processor; replaces bench-side $display polling.

---
 rtl/seq_pkg.sv | 56 +++++
 rtl/trace_fifo.sv | 56 +++++
 rtl/seq_retire_monitor.sv | 150 +++++++++++++++
 tb/tb_seq_retire_monitor.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared decode constants and run-monitor state encoding for seq_processor.
// The opcode constants are also used by the control unit decode.
package seq_pkg;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam int NCLASS = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_TOUT = 2'd3
    } mon_state_t;

    typedef enum logic [2:0] {
        CL_R   = 3'd0,
        CL_I   = 3'd1,
        CL_LD  = 3'd2,
        CL_ST  = 3'd3,
        CL_BR  = 3'd4,
        CL_OTH = 3'd5
    } instr_class_t;

    // A store that writes the register file, or a non-store that writes memory, is suspect.
    function automatic instr_class_t classify(input logic [31:0] instr,
                                              input logic        reg_write_en,
                                              input logic        mem_write);
        instr_class_t cls;
        case (instr[6:0])
            OP_R:    cls = CL_R;
            OP_I:    cls = CL_I;
            OP_LD:   cls = CL_LD;
            OP_ST:   cls = CL_ST;
            OP_BR:   cls = CL_BR;
            default: cls = CL_OTH;
        endcase
        if (cls == CL_ST) begin
            if (reg_write_en) begin
                cls = CL_OTH;
            end else begin
                cls = CL_ST;
            end
        end else if (mem_write) begin
            cls = CL_OTH;
        end else begin
            cls = cls;
        end
        return cls;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO for PC/instruction trace entries.
// Pointers carry one extra MSB so full and empty are distinguishable.
module trace_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]         head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign level = r_wr_ptr - r_rd_ptr;
    // Storage is not flushed on reset, so mask the head while empty.
    assign head  = empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr[AW-1:0]];

    // A pop frees the slot in the same cycle, so a push to a full FIFO still lands.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/seq_retire_monitor.sv
// Run-control and trace monitor for seq_processor: run FSM, retirement classifier,
// saturating per-class counters and a PC/instruction trace FIFO.
module seq_retire_monitor
    import seq_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TRACE_DEPTH = 16,
    parameter int CNT_W       = 32,
    parameter int MAX_CYCLES  = 500
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [XLEN-1:0]                pc,
    input  logic [31:0]                    instr,
    input  logic                           reg_write_en,
    input  logic                           mem_write,
    input  logic                           trace_rd,
    output logic                           running,
    output logic                           halted,
    output logic                           timeout,
    output logic [CNT_W-1:0]               cycle_count,
    output logic [CNT_W-1:0]               cnt_r,
    output logic [CNT_W-1:0]               cnt_i,
    output logic [CNT_W-1:0]               cnt_ld,
    output logic [CNT_W-1:0]               cnt_st,
    output logic [CNT_W-1:0]               cnt_br,
    output logic [CNT_W-1:0]               cnt_oth,
    output logic                           trace_valid,
    output logic [XLEN-1:0]                trace_pc,
    output logic [31:0]                    trace_instr,
    output logic [$clog2(TRACE_DEPTH):0]   trace_level,
    output logic                           trace_ovf
);

    localparam logic [CNT_W:0] BUDGET = (CNT_W+1)'(MAX_CYCLES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    mon_state_t                  r_state;
    mon_state_t                  w_state_nxt;
    logic                        r_running;
    logic                        r_halted;
    logic                        r_timeout;
    logic                        r_ovf;
    logic [CNT_W-1:0]            r_cycle_count;
    logic [NCLASS-1:0][CNT_W-1:0] r_cnt;
    logic                        w_in_run;
    logic                        w_is_halt;
    logic                        w_budget_hit;
    logic                        w_retire;
    instr_class_t                w_class;
    logic                        w_full;
    logic                        w_empty;
    logic [XLEN+31:0]            w_head;

    assign w_in_run     = (r_state == ST_RUN);
    assign w_is_halt    = (instr == 32'd0);
    assign w_budget_hit = (MAX_CYCLES != 0) && (({1'b0, r_cycle_count} + {{CNT_W{1'b0}}, 1'b1}) == BUDGET);
    assign w_retire     = w_in_run && !w_is_halt;
    assign w_class      = classify(instr, reg_write_en, mem_write);

    // Next-state logic; halt takes priority over budget expiry.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_is_halt) begin
                    w_state_nxt = ST_HALT;
                end else if (w_budget_hit) begin
                    w_state_nxt = ST_TOUT;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_HALT: w_state_nxt = ST_HALT;
            ST_TOUT: w_state_nxt = ST_TOUT;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_running     <= 1'b0;
            r_halted      <= 1'b0;
            r_timeout     <= 1'b0;
            r_ovf         <= 1'b0;
            r_cycle_count <= '0;
            r_cnt         <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == ST_RUN);
            r_halted  <= (w_state_nxt == ST_HALT);
            r_timeout <= (w_state_nxt == ST_TOUT);
            if (w_in_run) begin
                r_cycle_count <= sat_inc(r_cycle_count);
            end
            for (int k = 0; k < NCLASS; k++) begin
                if (w_retire && (w_class == instr_class_t'(k))) begin
                    r_cnt[k] <= sat_inc(r_cnt[k]);
                end
            end
            // Only a push that is actually dropped marks overflow.
            if (w_retire && w_full && !(trace_rd && !w_empty)) begin
                r_ovf <= 1'b1;
            end
        end
    end

    trace_fifo #(
        .WIDTH (XLEN + 32),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_retire),
        .pop   (trace_rd),
        .din   ({pc, instr}),
        .full  (w_full),
        .empty (w_empty),
        .level (trace_level),
        .head  (w_head)
    );

    assign running     = r_running;
    assign halted      = r_halted;
    assign timeout     = r_timeout;
    assign cycle_count = r_cycle_count;
    assign cnt_r       = r_cnt[CL_R];
    assign cnt_i       = r_cnt[CL_I];
    assign cnt_ld      = r_cnt[CL_LD];
    assign cnt_st      = r_cnt[CL_ST];
    assign cnt_br      = r_cnt[CL_BR];
    assign cnt_oth     = r_cnt[CL_OTH];
    assign trace_valid = !w_empty;
    assign trace_pc    = w_head[XLEN+31:32];
    assign trace_instr = w_head[31:0];
    assign trace_ovf   = r_ovf;

endmodule

// File: tb/tb_seq_retire_monitor.sv
// Directed bench for seq_retire_monitor: a small-budget instance plus a narrow-counter,
// unlimited-budget instance sharing the same stimulus.
module tb_seq_retire_monitor;

    localparam logic [31:0] I_R   = 32'h002081B3;
    localparam logic [31:0] I_I   = 32'h00108093;
    localparam logic [31:0] I_LD  = 32'h0000A103;
    localparam logic [31:0] I_ST  = 32'h0020A023;
    localparam logic [31:0] I_BR  = 32'h00208463;
    localparam logic [31:0] I_LUI = 32'h000000B7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] pc = 32'd0;
    logic [31:0] instr = 32'd0;
    logic        reg_write_en = 1'b0;
    logic        mem_write = 1'b0;
    logic        trace_rd = 1'b0;

    logic        running, halted, timeout, trace_valid, trace_ovf;
    logic [31:0] cycle_count, cnt_r, cnt_i, cnt_ld, cnt_st, cnt_br, cnt_oth;
    logic [31:0] trace_pc, trace_instr;
    logic [2:0]  trace_level;

    logic        s_running, s_halted, s_timeout, s_trace_valid, s_trace_ovf;
    logic [2:0]  s_cycle_count, s_cnt_r, s_cnt_i, s_cnt_ld, s_cnt_st, s_cnt_br, s_cnt_oth;
    logic [31:0] s_trace_pc, s_trace_instr;
    logic [2:0]  s_trace_level;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    seq_retire_monitor #(.XLEN(32), .TRACE_DEPTH(4), .CNT_W(32), .MAX_CYCLES(8)) u_dut (
        .clk(clk), .reset(reset), .start(start), .pc(pc), .instr(instr),
        .reg_write_en(reg_write_en), .mem_write(mem_write), .trace_rd(trace_rd),
        .running(running), .halted(halted), .timeout(timeout), .cycle_count(cycle_count),
        .cnt_r(cnt_r), .cnt_i(cnt_i), .cnt_ld(cnt_ld), .cnt_st(cnt_st), .cnt_br(cnt_br),
        .cnt_oth(cnt_oth), .trace_valid(trace_valid), .trace_pc(trace_pc),
        .trace_instr(trace_instr), .trace_level(trace_level), .trace_ovf(trace_ovf)
    );

    seq_retire_monitor #(.XLEN(32), .TRACE_DEPTH(4), .CNT_W(3), .MAX_CYCLES(0)) u_sat (
        .clk(clk), .reset(reset), .start(start), .pc(pc), .instr(instr),
        .reg_write_en(reg_write_en), .mem_write(mem_write), .trace_rd(trace_rd),
        .running(s_running), .halted(s_halted), .timeout(s_timeout), .cycle_count(s_cycle_count),
        .cnt_r(s_cnt_r), .cnt_i(s_cnt_i), .cnt_ld(s_cnt_ld), .cnt_st(s_cnt_st), .cnt_br(s_cnt_br),
        .cnt_oth(s_cnt_oth), .trace_valid(s_trace_valid), .trace_pc(s_trace_pc),
        .trace_instr(s_trace_instr), .trace_level(s_trace_level), .trace_ovf(s_trace_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc(input logic st, input logic [31:0] p, input logic [31:0] ins,
                       input logic rw, input logic mw, input logic rd);
        start = st; pc = p; instr = ins; reg_write_en = rw; mem_write = mw; trace_rd = rd;
        @(posedge clk);
        #1;
        start = 1'b0;
        trace_rd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Reset values, checked while reset is held.
        #2;
        chk("rst_running", 64'(running), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        chk("rst_cycles", 64'(cycle_count), 64'd0);
        chk("rst_counts", 64'(cnt_r | cnt_i | cnt_ld | cnt_st | cnt_br | cnt_oth), 64'd0);
        chk("rst_fifo", 64'({trace_valid, trace_level, trace_ovf, trace_pc, trace_instr}), 64'd0);
        chk("rst_sat", 64'({s_running, s_halted, s_timeout, s_cycle_count, s_cnt_r, s_cnt_i,
                            s_cnt_ld, s_cnt_st, s_cnt_br, s_cnt_oth, s_trace_valid,
                            s_trace_level, s_trace_ovf, s_trace_pc, s_trace_instr}), 64'd0);
        do_reset();

        // Three retirements then halt.
        cyc(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t1_running", 64'(running), 64'd1);
        chk("t1_cyc0", 64'(cycle_count), 64'd0);
        cyc(1'b0, 32'h0, I_R, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h4, I_I, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h8, I_LD, 1'b1, 1'b0, 1'b0);
        chk("t1_not_halted", 64'(halted), 64'd0);
        chk("t1_cyc3", 64'(cycle_count), 64'd3);
        cyc(1'b0, 32'hC, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t1_halted", 64'(halted), 64'd1);
        chk("t1_stopped", 64'(running), 64'd0);
        chk("t1_timeout", 64'(timeout), 64'd0);
        chk("t1_cnt_r", 64'(cnt_r), 64'd1);
        chk("t1_cnt_i", 64'(cnt_i), 64'd1);
        chk("t1_cnt_ld", 64'(cnt_ld), 64'd1);
        chk("t1_cnt_oth", 64'(cnt_oth), 64'd0);
        chk("t1_cyc4", 64'(cycle_count), 64'd4);
        chk("t1_level", 64'(trace_level), 64'd3);
        cyc(1'b1, 32'h10, I_R, 1'b1, 1'b0, 1'b0);
        chk("t1_start_ignored", 64'({halted, running}), 64'b10);
        chk("t1_frozen_cyc", 64'(cycle_count), 64'd4);
        chk("t1_frozen_level", 64'(trace_level), 64'd3);

        // Budget of 8 cycles; the narrow instance keeps running and saturates.
        do_reset();
        cyc(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 32'(4 * i), I_I, 1'b1, 1'b0, 1'b0);
        chk("t2_no_timeout_yet", 64'(timeout), 64'd0);
        cyc(1'b0, 32'h1C, I_I, 1'b1, 1'b0, 1'b0);
        chk("t2_timeout", 64'(timeout), 64'd1);
        chk("t2_halted", 64'(halted), 64'd0);
        chk("t2_running", 64'(running), 64'd0);
        chk("t2_cyc8", 64'(cycle_count), 64'd8);
        chk("t2_cnt_i", 64'(cnt_i), 64'd8);
        cyc(1'b0, 32'h20, I_I, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h24, I_I, 1'b1, 1'b0, 1'b0);
        chk("t2_cyc_frozen", 64'(cycle_count), 64'd8);
        chk("t2_cnt_i_frozen", 64'(cnt_i), 64'd8);
        chk("t2_sat_cyc", 64'(s_cycle_count), 64'd7);
        chk("t2_sat_cnt_i", 64'(s_cnt_i), 64'd7);
        chk("t2_sat_running", 64'({s_running, s_timeout}), 64'b10);
        chk("t2_sat_fifo", 64'({s_trace_level, s_trace_ovf}), 64'b1001);

        // Overflow, ordered drain, pop on empty.
        do_reset();
        cyc(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 32'(4 * i), I_R, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h18, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t3_halted", 64'(halted), 64'd1);
        chk("t3_level", 64'(trace_level), 64'd4);
        chk("t3_ovf", 64'(trace_ovf), 64'd1);
        chk("t3_head_instr", 64'(trace_instr), 64'(I_R));
        for (int i = 0; i < 4; i++) begin
            chk("t3_pop_pc", 64'({trace_valid, trace_pc}), {31'd0, 1'b1, 32'(4 * i)});
            cyc(1'b0, 32'h18, 32'h0, 1'b0, 1'b0, 1'b1);
        end
        chk("t3_drained", 64'({trace_valid, trace_level}), 64'd0);
        cyc(1'b0, 32'h18, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("t3_pop_empty", 64'({trace_valid, trace_level, trace_ovf}), 64'b00001);

        // Cross-check classification, then simultaneous push/pop while full.
        do_reset();
        cyc(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h100, I_ST, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 32'h104, I_ST, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'h108, I_BR, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'h10C, I_BR, 1'b0, 1'b0, 1'b0);
        chk("t4_full", 64'({trace_level, trace_ovf}), 64'b1000);
        chk("t4_head0", 64'(trace_pc), 64'h100);
        chk("t4_cnt_st", 64'(cnt_st), 64'd1);
        chk("t4_cnt_br", 64'(cnt_br), 64'd1);
        chk("t4_cnt_oth", 64'(cnt_oth), 64'd2);
        cyc(1'b0, 32'h110, I_LUI, 1'b1, 1'b0, 1'b1);
        chk("t4_pushpop_level", 64'(trace_level), 64'd4);
        chk("t4_pushpop_ovf", 64'(trace_ovf), 64'd0);
        chk("t4_head1", 64'(trace_pc), 64'h104);
        chk("t4_cnt_oth2", 64'(cnt_oth), 64'd3);
        cyc(1'b0, 32'h114, I_R, 1'b1, 1'b0, 1'b0);
        chk("t4_drop", 64'({trace_level, trace_ovf}), 64'b1001);
        chk("t4_head_kept", 64'(trace_pc), 64'h104);

        // Halt on the same cycle the budget expires.
        do_reset();
        cyc(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 32'(4 * i), I_R, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h1C, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t5_halt_wins", 64'({halted, timeout, running}), 64'b100);
        chk("t5_cyc8", 64'(cycle_count), 64'd8);
        chk("t5_cnt_r", 64'(cnt_r), 64'd7);

        // Asynchronous reset mid-run, then a fresh run.
        do_reset();
        cyc(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h200 + 32'(4 * i), I_R, 1'b1, 1'b0, 1'b0);
        chk("t6_level3", 64'(trace_level), 64'd3);
        reset = 1'b1;
        #1;
        chk("t6_async_state", 64'({running, halted, timeout}), 64'd0);
        chk("t6_async_cyc", 64'(cycle_count), 64'd0);
        chk("t6_async_cnt", 64'(cnt_r), 64'd0);
        chk("t6_async_fifo", 64'({trace_valid, trace_level, trace_pc}), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t6_restart", 64'({running, cycle_count}), {31'd0, 1'b1, 32'd0});
        cyc(1'b0, 32'h300, I_I, 1'b1, 1'b0, 1'b1);
        chk("t6_pushpop_empty", 64'({trace_valid, trace_level}), 64'b1001);
        chk("t6_head", 64'(trace_pc), 64'h300);
        chk("t6_cyc1", 64'(cycle_count), 64'd1);
        chk("t6_cnts", 64'({cnt_i, cnt_r}), {32'd1, 32'd0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
